// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types, geometry defaults and on-time helper for the HUB75 scan scheduler
package hub75_pkg;

   localparam int HUB75_PIXELS  = 128;
   localparam int HUB75_ROWS    = 16;
   localparam int HUB75_PLANES  = 4;
   localparam int HUB75_CLKDIV  = 4;
   localparam int HUB75_LINELEN = 488;
   localparam int HUB75_BASE_ON = 50;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT,
      WAIT,
      LATCH
   } state_t;

   // Binary-weighted display time, in ticks, for a bitplane.
   function automatic int unsigned on_time(input int unsigned base_on, input int unsigned plane_i);
      return base_on << plane_i;
   endfunction

endpackage

// File: rtl/hub75_tick_gen.sv
// rtl/hub75_tick_gen.sv - prescaler producing one tick every CLKDIV clocks, restartable by clear
module hub75_tick_gen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(CLKDIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hub75_scan_scheduler.sv
// rtl/hub75_scan_scheduler.sv - HUB75 bitplane/row sequencer: fetch, shift, latch and weighted OE
module hub75_scan_scheduler
   import hub75_pkg::*;
#(
   parameter int PIXELS  = HUB75_PIXELS,
   parameter int ROWS    = HUB75_ROWS,
   parameter int PLANES  = HUB75_PLANES,
   parameter int CLKDIV  = HUB75_CLKDIV,
   parameter int LINELEN = HUB75_LINELEN,
   parameter int BASE_ON = HUB75_BASE_ON
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   output logic                      row_req,
   input  logic                      row_ack,
   output logic [$clog2(ROWS)-1:0]   row_addr,
   output logic [$clog2(PLANES)-1:0] plane,
   output logic [$clog2(PIXELS)-1:0] pixel_idx,
   output logic                      pix_valid,
   output logic                      hub75_clk,
   output logic                      hub75_lat,
   output logic                      hub75_oe,
   output logic [$clog2(ROWS)-1:0]   hub75_addr,
   output logic                      frame_start
);

   localparam int PW = $clog2(PIXELS);
   localparam int RW = $clog2(ROWS);
   localparam int LW = $clog2(PLANES);
   localparam int TW = $clog2(LINELEN);

   localparam logic [TW-1:0] T_SHIFT_END = TW'(2 * PIXELS - 1);
   localparam logic [TW-1:0] T_LATCH     = TW'(LINELEN - 2);
   localparam logic [TW-1:0] T_LAST      = TW'(LINELEN - 1);

   if (2 * PIXELS > LINELEN - 2) begin : g_chk_shift
      $fatal(1, "hub75_scan_scheduler: shift phase does not fit in LINELEN");
   end
   if ((BASE_ON << (PLANES - 1)) > LINELEN - 3) begin : g_chk_oe
      $fatal(1, "hub75_scan_scheduler: longest on-time does not fit in LINELEN");
   end
   if (((PIXELS & (PIXELS - 1)) != 0) || ((ROWS & (ROWS - 1)) != 0) ||
       ((PLANES & (PLANES - 1)) != 0)) begin : g_chk_pow2
      $fatal(1, "hub75_scan_scheduler: PIXELS, ROWS and PLANES must be powers of 2");
   end

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic            row_req_q, row_req_d;
   logic [RW-1:0]   row_addr_q, row_addr_d;
   logic [LW-1:0]   plane_q, plane_d;
   logic [PW-1:0]   pixel_idx_q, pixel_idx_d;
   logic            pix_valid_q, pix_valid_d;
   logic            hclk_q, hclk_d;
   logic            lat_q, lat_d;
   logic            oe_q, oe_d;
   logic [RW-1:0]   addr_q, addr_d;
   logic            frame_start_q, frame_start_d;
   logic [LW-1:0]   disp_plane_q, disp_plane_d;
   logic            disp_valid_q, disp_valid_d;

   logic tick;
   logic ack_acc;
   logic slot_end;

   assign ack_acc  = (state_q == FETCH) && row_req_q && row_ack;
   assign slot_end = (state_q == LATCH) && tick && (t_q == T_LAST);

   hub75_tick_gen #(
      .CLKDIV (CLKDIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (ack_acc),
      .tick_o  (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         t_q           <= '0;
         row_req_q     <= 1'b0;
         row_addr_q    <= '0;
         plane_q       <= '0;
         pixel_idx_q   <= '0;
         pix_valid_q   <= 1'b0;
         hclk_q        <= 1'b0;
         lat_q         <= 1'b0;
         oe_q          <= 1'b1;
         addr_q        <= '0;
         frame_start_q <= 1'b0;
         disp_plane_q  <= '0;
         disp_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         t_q           <= t_d;
         row_req_q     <= row_req_d;
         row_addr_q    <= row_addr_d;
         plane_q       <= plane_d;
         pixel_idx_q   <= pixel_idx_d;
         pix_valid_q   <= pix_valid_d;
         hclk_q        <= hclk_d;
         lat_q         <= lat_d;
         oe_q          <= oe_d;
         addr_q        <= addr_d;
         frame_start_q <= frame_start_d;
         disp_plane_q  <= disp_plane_d;
         disp_valid_q  <= disp_valid_d;
      end
   end

   // t stays frozen in FETCH so a slow row source only stretches the blanked gap.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      unique case (state_q)
         IDLE: begin
            if (enable) state_d = FETCH;
         end
         FETCH: begin
            if (ack_acc) begin
               state_d = SHIFT;
               t_d     = '0;
            end
         end
         SHIFT: begin
            if (tick) begin
               t_d = t_q + TW'(1);
               if (t_q == T_SHIFT_END) begin
                  state_d = (t_d == T_LATCH) ? LATCH : WAIT;
               end
            end
         end
         WAIT: begin
            if (tick) begin
               t_d = t_q + TW'(1);
               if (t_d == T_LATCH) state_d = LATCH;
            end
         end
         LATCH: begin
            if (tick) begin
               if (t_q == T_LAST) begin
                  state_d = enable ? FETCH : IDLE;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so the registered pins line up with t_q.
   always_comb begin
      row_addr_d    = row_addr_q;
      plane_d       = plane_q;
      addr_d        = addr_q;
      disp_plane_d  = disp_plane_q;
      disp_valid_d  = disp_valid_q;
      frame_start_d = 1'b0;
      if (slot_end) begin
         addr_d       = row_addr_q;
         disp_plane_d = plane_q;
         disp_valid_d = 1'b1;
         plane_d      = plane_q + LW'(1);
         if (plane_q == LW'(PLANES - 1)) begin
            row_addr_d = row_addr_q + RW'(1);
            if (row_addr_q == RW'(ROWS - 1)) frame_start_d = 1'b1;
         end
      end

      row_req_d   = (state_q == FETCH) && !ack_acc;
      pix_valid_d = (state_d == SHIFT);
      pixel_idx_d = (state_d == SHIFT) ? t_d[PW:1] : '0;
      hclk_d      = (state_d == SHIFT) && t_d[0];
      lat_d       = (state_d == LATCH) && (t_d == T_LATCH);
      oe_d        = !(disp_valid_d && ((state_d == SHIFT) || (state_d == WAIT)) &&
                      (32'(t_d) < on_time(BASE_ON, 32'(disp_plane_d))));
   end

   assign row_req     = row_req_q;
   assign row_addr    = row_addr_q;
   assign plane       = plane_q;
   assign pixel_idx   = pixel_idx_q;
   assign pix_valid   = pix_valid_q;
   assign hub75_clk   = hclk_q;
   assign hub75_lat   = lat_q;
   assign hub75_oe    = oe_q;
   assign hub75_addr  = addr_q;
   assign frame_start = frame_start_q;

endmodule
